axis_video_frame_source: RTL and testbench

//  AXI4-Stream video master that generates complete frames of HEIGHT x WIDTH pixels.

---
 rtl/axis_video_frame_source.sv | 136 +++++++++++++
 tb/tb_axis_video_frame_source.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_video_frame_source.sv
// AXI4-Stream video master: emits HEIGHT x WIDTH ramp frames with tuser on the first
// pixel and tlast at end of line, honouring tready back-pressure, single-shot or continuous.
module axis_video_frame_source #(
    parameter int N          = 8,
    parameter int HEIGHT     = 355,
    parameter int WIDTH      = 355,
    parameter int GAP_CYCLES = 4
) (
    input  logic         i_sys_clk,
    input  logic         i_sys_aresetn,
    input  logic         i_start,
    input  logic         i_continuous,
    input  logic         i_video_tready,
    output logic [N-1:0] o_video_tdata,
    output logic         o_video_tvalid,
    output logic         o_video_tlast,
    output logic         o_video_tuser,
    output logic         o_busy,
    output logic         o_frame_done,
    output logic [15:0]  o_frame_count
);

    localparam int CW = 12;
    localparam logic [CW-1:0] LAST_PIX  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_LINE = CW'(HEIGHT - 1);
    localparam logic [15:0]   GAP_LAST  = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

    state_t        state_q;
    logic [CW-1:0] pixel_cnt_q, pixel_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [15:0]   gap_cnt_q;
    logic [15:0]   frame_count_q, frame_count_d;
    logic [N-1:0]  tdata_q;
    logic          tvalid_q, tlast_q, tuser_q, busy_q, done_q;
    logic          xfer, last_pix, last_beat, end_of_frame, gap_done, launch;

    // Ramp value of a beat: pixel + line + frame index, truncated to the pixel width.
    function automatic logic [N-1:0] ramp(input logic [CW-1:0] pix, input logic [CW-1:0] line,
                                          input logic [15:0] fc);
        logic [31:0] sum;
        sum = 32'(pix) + 32'(line) + 32'(fc);
        return sum[N-1:0];
    endfunction

    // NOTE: every signal gets a value on every path here, so no latch can be inferred.
    always_comb begin
        xfer          = tvalid_q & i_video_tready;
        last_pix      = (pixel_cnt_q == LAST_PIX);
        last_beat     = last_pix && (line_cnt_q == LAST_LINE);
        end_of_frame  = (state_q == S_SEND) && xfer && last_beat;
        gap_done      = (state_q == S_GAP) && (gap_cnt_q == GAP_LAST);
        launch        = (i_start | i_continuous) &&
                        ((state_q == S_IDLE) || gap_done || (end_of_frame && (GAP_CYCLES == 0)));
        frame_count_d = end_of_frame ? frame_count_q + 16'd1 : frame_count_q;
        pixel_cnt_d   = last_pix ? '0 : pixel_cnt_q + 1'b1;
        line_cnt_d    = last_pix ? line_cnt_q + 1'b1 : line_cnt_q;
    end

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q       <= S_IDLE;
            pixel_cnt_q   <= '0;
            line_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            frame_count_q <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= end_of_frame;
            frame_count_q <= frame_count_d;
            if (launch) begin
                // Present beat (0,0) of a new frame; data uses the already-updated frame index.
                state_q     <= S_SEND;
                pixel_cnt_q <= '0;
                line_cnt_q  <= '0;
                gap_cnt_q   <= '0;
                tvalid_q    <= 1'b1;
                tuser_q     <= 1'b1;
                tlast_q     <= (WIDTH == 1);
                tdata_q     <= ramp('0, '0, frame_count_d);
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    S_SEND: begin
                        if (xfer) begin
                            if (last_beat) begin
                                tvalid_q  <= 1'b0;
                                tlast_q   <= 1'b0;
                                tuser_q   <= 1'b0;
                                tdata_q   <= '0;
                                gap_cnt_q <= '0;
                                if (GAP_CYCLES > 0) begin
                                    state_q <= S_GAP;
                                end else begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                pixel_cnt_q <= pixel_cnt_d;
                                line_cnt_q  <= line_cnt_d;
                                tuser_q     <= 1'b0;
                                tlast_q     <= (pixel_cnt_d == LAST_PIX);
                                tdata_q     <= ramp(pixel_cnt_d, line_cnt_d, frame_count_q);
                            end
                        end
                    end
                    S_GAP: begin
                        if (gap_done) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign o_video_tdata  = tdata_q;
    assign o_video_tvalid = tvalid_q;
    assign o_video_tlast  = tlast_q;
    assign o_video_tuser  = tuser_q;
    assign o_busy         = busy_q;
    assign o_frame_done   = done_q;
    assign o_frame_count  = frame_count_q;

endmodule

// File: tb/tb_axis_video_frame_source.sv
// Self-checking bench: three source instances (4x3 gap 2, 4x3 gap 0, 1x1 gap 2) driven
// together with randomized back-pressure and compared beat-by-beat against a frame model.
`timescale 1ns/1ps
module tb_axis_video_frame_source;

    localparam int ND = 3;
    localparam int W[ND] = '{4, 4, 1};
    localparam int H[ND] = '{3, 3, 1};
    localparam int G[ND] = '{2, 0, 2};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, cont = 1'b0, tready = 1'b0;
    logic [7:0]  tdata [ND];
    logic        tvalid[ND], tlast[ND], tuser[ND], busy[ND], done[ND];
    logic [15:0] fcnt  [ND];

    axis_video_frame_source #(.N(8), .HEIGHT(3), .WIDTH(4), .GAP_CYCLES(2)) dut_a (
        .i_sys_clk(clk), .i_sys_aresetn(rst_n), .i_start(start), .i_continuous(cont),
        .i_video_tready(tready), .o_video_tdata(tdata[0]), .o_video_tvalid(tvalid[0]),
        .o_video_tlast(tlast[0]), .o_video_tuser(tuser[0]), .o_busy(busy[0]),
        .o_frame_done(done[0]), .o_frame_count(fcnt[0]));
    axis_video_frame_source #(.N(8), .HEIGHT(3), .WIDTH(4), .GAP_CYCLES(0)) dut_b (
        .i_sys_clk(clk), .i_sys_aresetn(rst_n), .i_start(start), .i_continuous(cont),
        .i_video_tready(tready), .o_video_tdata(tdata[1]), .o_video_tvalid(tvalid[1]),
        .o_video_tlast(tlast[1]), .o_video_tuser(tuser[1]), .o_busy(busy[1]),
        .o_frame_done(done[1]), .o_frame_count(fcnt[1]));
    axis_video_frame_source #(.N(8), .HEIGHT(1), .WIDTH(1), .GAP_CYCLES(2)) dut_c (
        .i_sys_clk(clk), .i_sys_aresetn(rst_n), .i_start(start), .i_continuous(cont),
        .i_video_tready(tready), .o_video_tdata(tdata[2]), .o_video_tvalid(tvalid[2]),
        .o_video_tlast(tlast[2]), .o_video_tuser(tuser[2]), .o_busy(busy[2]),
        .o_frame_done(done[2]), .o_frame_count(fcnt[2]));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: beats accepted in the current frame, frames completed, gap tracking.
    int beat[ND], frames[ND], idle[ND];
    bit done_pend[ND], in_gap[ND];
    bit gap_chk = 1'b0;

    always @(negedge clk) begin
        int p, l;
        for (int i = 0; i < ND; i++) begin
            if (!rst_n) begin
                beat[i] = 0; frames[i] = 0; idle[i] = 0;
                done_pend[i] = 1'b0; in_gap[i] = 1'b0;
            end else begin
                p = beat[i] % W[i];
                l = beat[i] / W[i];
                check($sformatf("d%0d_frame_done", i), done[i], done_pend[i]);
                check($sformatf("d%0d_frame_count", i), fcnt[i], frames[i] & 16'hffff);
                done_pend[i] = 1'b0;
                if (!gap_chk) in_gap[i] = 1'b0;
                if (tvalid[i]) begin
                    check($sformatf("d%0d_tdata", i), tdata[i], (p + l + frames[i]) % 256);
                    check($sformatf("d%0d_tlast", i), tlast[i], p == W[i] - 1);
                    check($sformatf("d%0d_tuser", i), tuser[i], beat[i] == 0);
                    check($sformatf("d%0d_busy", i), busy[i], 1);
                    if (in_gap[i]) check($sformatf("d%0d_gap_len", i), idle[i], G[i]);
                    in_gap[i] = 1'b0;
                    if (tready) begin
                        beat[i]++;
                        if (beat[i] == W[i] * H[i]) begin
                            beat[i] = 0;
                            frames[i]++;
                            done_pend[i] = 1'b1;
                            in_gap[i] = gap_chk;
                            idle[i] = 0;
                        end
                    end
                end else if (in_gap[i]) begin
                    idle[i]++;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("%s_d%0d_tvalid", tag, i), tvalid[i], 0);
            check($sformatf("%s_d%0d_tdata", tag, i), tdata[i], 0);
            check($sformatf("%s_d%0d_tlast", tag, i), tlast[i], 0);
            check($sformatf("%s_d%0d_tuser", tag, i), tuser[i], 0);
            check($sformatf("%s_d%0d_busy", tag, i), busy[i], 0);
            check($sformatf("%s_d%0d_done", tag, i), done[i], 0);
            check($sformatf("%s_d%0d_count", tag, i), fcnt[i], 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; tready = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic tick(input bit rnd);
        @(posedge clk);
        #1;
        if (rnd) tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_frames(input int idx, input int n, input int budget, input bit rnd);
        for (int c = 0; c < budget && frames[idx] < n; c++) tick(rnd);
        check($sformatf("wait_frames_d%0d_%0d", idx, n), frames[idx] >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && (busy[0] | busy[1] | busy[2]); c++) tick(1'b0);
        check("wait_idle", busy[0] | busy[1] | busy[2], 0);
    endtask

    initial begin
        #2;
        // Single-shot frame, no back-pressure; 1-cycle start latency.
        do_reset();
        tready = 1'b1;
        pulse_start();
        check("t1_lat_valid", tvalid[0], 1);
        check("t1_lat_user", tuser[0], 1);
        check("t1_lat_data", tdata[0], 0);
        check("t6_user_last", {tuser[2], tlast[2]}, 2'b11);
        wait_frames(0, 1, 200, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("t1_idle_busy", busy[0], 0);
        check("t1_idle_valid", tvalid[0], 0);
        check("t1_count", fcnt[0], 1);
        check("t6_count", fcnt[2], 1);

        // Toggling tready with a 5-cycle stall, then a frame under random tready.
        do_reset();
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            start  = (c == 0);
            tready = (c >= 7 && c < 12) ? 1'b0 : (c % 2 == 0);
        end
        tready = 1'b1;
        wait_frames(0, 1, 100, 1'b0);
        pulse_start();
        wait_frames(0, 2, 400, 1'b1);
        tready = 1'b1;
        wait_idle(50);
        check("t2_count", fcnt[0], 2);

        // Continuous frames with random back-pressure, gap lengths checked by the model.
        do_reset();
        gap_chk = 1'b1;
        cont = 1'b1;
        wait_frames(0, 2, 1000, 1'b1);
        for (int c = 0; c < 50 && !tvalid[0]; c++) tick(1'b1);
        check("t3_frame3_started", tvalid[0], 1);
        cont = 1'b0;
        gap_chk = 1'b0;
        tready = 1'b1;
        wait_idle(100);
        check("t3_count", fcnt[0], 3);

        // Asynchronous reset mid-frame, then restart.
        do_reset();
        tready = 1'b1;
        pulse_start();
        for (int c = 0; c < 50 && beat[0] < 6; c++) tick(1'b0);
        check("t5_reached_beat6", beat[0], 6);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("t5_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        check("t5_restart_valid", tvalid[0], 1);
        check("t5_restart_data", tdata[0], 0);
        check("t5_restart_user", tuser[0], 1);
        check("t5_restart_count", fcnt[0], 0);
        wait_frames(0, 1, 100, 1'b1);
        tready = 1'b1;
        wait_idle(50);
        check("t5_count", fcnt[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
